// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: valid/ready data-memory bus between the load/store controller and memory.
// master = controller side, slave = memory side.
interface lsu_ctrl_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_wstrb,
        output bus_wdata,
        input  bus_ready,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wstrb,
        input  bus_wdata,
        output bus_ready,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store sequencer driving a valid/ready bus, with a hang watchdog.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  ByteAccess,
    input  logic [2:0]  ByteSrc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_fault,
    output logic [31:0] rdata,
    lsu_ctrl_if.master  bus
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] WdogLast = CntW'(TIMEOUT - 1);
    localparam bit WdogEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e          state_q;
    logic            bus_valid_q;
    logic [CntW-1:0] wdog_q;
    logic            we_q;
    logic [1:0]      ba_q;
    logic [2:0]      bs_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;

    logic [3:0]  wstrb;
    logic [31:0] wdata_rep;
    logic [4:0]  lane_sh;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic        wdog_hit;

    assign lsu_stall = mem_req & ~lsu_done;
    assign wdog_hit  = WdogEn && (wdog_q == WdogLast);

    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_wstrb = wstrb;
    assign bus.bus_wdata = wdata_rep;

    // Offending low address bits are ignored: half uses addr[1] only, word uses lane 0.
    always_comb begin
        case (ba_q)
            2'b01: begin
                wstrb     = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
                lane_sh   = {addr_q[1:0], 3'b000};
            end
            2'b10: begin
                wstrb     = 4'b0011 << {addr_q[1], 1'b0};
                wdata_rep = {2{wdata_q[15:0]}};
                lane_sh   = {addr_q[1], 4'b0000};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata_q;
                lane_sh   = 5'd0;
            end
        endcase
        if (!we_q) begin
            wstrb = 4'b0000;
        end
    end

    always_comb begin
        lane = bus.bus_rdata >> lane_sh;
        case (bs_q)
            3'b000:  load_ext = {24'b0, lane[7:0]};
            3'b001:  load_ext = {16'b0, lane[15:0]};
            3'b010:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b011:  load_ext = {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    always_comb begin
        case (ByteAccess)
            2'b01:   misalign = 1'b0;
            2'b10:   misalign = addr[0];
            default: misalign = (addr[1:0] != 2'b00);
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bus_valid_q <= 1'b0;
            wdog_q      <= '0;
            we_q        <= 1'b0;
            ba_q        <= '0;
            bs_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lsu_done    <= 1'b0;
            lsu_fault   <= 1'b0;
            rdata       <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            lsu_done  <= 1'b0;
            lsu_fault <= 1'b0;
            rdata     <= '0;
            case (state_q)
                StIdle: begin
                    if (mem_req) begin
                        we_q    <= mem_we;
                        ba_q    <= ByteAccess;
                        bs_q    <= ByteSrc;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wdog_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state_q   <= StDone;
                            lsu_done  <= 1'b1;
                            lsu_fault <= 1'b1;
                        end else begin
                            state_q     <= StReq;
                            bus_valid_q <= 1'b1;
                        end
`else
                        state_q     <= StReq;
                        bus_valid_q <= 1'b1;
`endif
                    end
                end
                StReq: begin
                    if (bus.bus_ready) begin
                        bus_valid_q <= 1'b0;
                        wdog_q      <= '0;
                        if (we_q) begin
                            state_q  <= StDone;
                            lsu_done <= 1'b1;
                        end else if (bus.bus_rvalid) begin
                            state_q  <= StDone;
                            lsu_done <= 1'b1;
                            rdata    <= load_ext;
                        end else begin
                            state_q <= StWaitR;
                        end
                    end else if (wdog_hit) begin
                        state_q     <= StDone;
                        bus_valid_q <= 1'b0;
                        lsu_done    <= 1'b1;
                        lsu_fault   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + CntW'(1);
                    end
                end
                StWaitR: begin
                    if (bus.bus_rvalid) begin
                        state_q  <= StDone;
                        lsu_done <= 1'b1;
                        rdata    <= load_ext;
                    end else if (wdog_hit) begin
                        state_q   <= StDone;
                        lsu_done  <= 1'b1;
                        lsu_fault <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven directed bench for lsu_ctrl plus reset and back-to-back sequences.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_ctrl;
    logic        clk;
    logic        reset_n;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  ByteAccess;
    logic [2:0]  ByteSrc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_fault;
    logic [31:0] rdata;

    lsu_ctrl_if bif ();

    lsu_ctrl #(.TIMEOUT(255)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ByteAccess (ByteAccess),
        .ByteSrc    (ByteSrc),
        .addr       (addr),
        .wdata      (wdata),
        .lsu_stall  (lsu_stall),
        .lsu_done   (lsu_done),
        .lsu_fault  (lsu_fault),
        .rdata      (rdata),
        .bus        (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit [1:0]    ba;
        bit [2:0]    bs;
        bit [31:0]   addr;
        bit [31:0]   wdata;
        bit [31:0]   brdata;
        int          rdy_dly;  // valid cycles before bus_ready
        int          rv_dly;   // cycles after acceptance before rvalid (0 = with ready)
        bit          drop;     // release mem_req after cycle 0
        bit [31:0]   e_baddr;
        bit [3:0]    e_wstrb;
        bit [31:0]   e_bwdata;
        bit [31:0]   e_rdata;
        bit          e_fault;
        int          e_done;   // cycle of lsu_done, request presented in cycle 0
        int          e_vcnt;   // cycles with bus_valid high
    } vec_t;

    vec_t vecs[13];
    int   n_tests;
    int   n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int          vcnt;
        int          wcnt;
        int          done_cyc;
        bit          accepted;
        bit          seen;
        bit          stable;
        logic [31:0] c_addr;
        logic [3:0]  c_wstrb;
        logic [31:0] c_wdata;
        logic        c_we;
        logic [31:0] g_rdata;
        logic        g_fault;
        logic        g_stall;
        vcnt = 0; wcnt = 0; done_cyc = -1; accepted = 0; seen = 0; stable = 1;
        c_addr = '0; c_wstrb = '0; c_wdata = '0; c_we = 0;
        g_rdata = '0; g_fault = 0; g_stall = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = v.we; ByteAccess = v.ba; ByteSrc = v.bs;
        addr = v.addr; wdata = v.wdata;
        bif.bus_rdata = v.brdata; bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk({nm, ".stall_c1"}, lsu_stall, (v.e_done != 1));
                if (v.drop) mem_req = 1'b0;
            end
            if (lsu_done) begin
                done_cyc = cyc; g_rdata = rdata; g_fault = lsu_fault; g_stall = lsu_stall;
                break;
            end
            if (bif.bus_valid) begin
                if (!seen) begin
                    c_addr = bif.bus_addr; c_wstrb = bif.bus_wstrb;
                    c_wdata = bif.bus_wdata; c_we = bif.bus_we;
                    seen = 1;
                end else if (bif.bus_addr !== c_addr || bif.bus_wstrb !== c_wstrb ||
                             bif.bus_wdata !== c_wdata) begin
                    stable = 0;
                end
                bif.bus_ready  = (vcnt == v.rdy_dly);
                bif.bus_rvalid = bif.bus_ready && !v.we && (v.rv_dly == 0);
                if (bif.bus_ready) accepted = 1;
                vcnt++;
            end else if (accepted) begin
                wcnt++;
                bif.bus_ready  = 1'b0;
                bif.bus_rvalid = (wcnt == v.rv_dly);
            end
        end
        mem_req = 1'b0; bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0;
        chk({nm, ".done_cycle"}, done_cyc, v.e_done);
        chk({nm, ".rdata"}, g_rdata, v.e_rdata);
        chk({nm, ".fault"}, g_fault, v.e_fault);
        chk({nm, ".stall_done"}, g_stall, 0);
        chk({nm, ".valid_cycles"}, vcnt, v.e_vcnt);
        chk({nm, ".bus_stable"}, stable, 1);
        if (v.e_vcnt != 0) begin
            chk({nm, ".bus_addr"}, c_addr, v.e_baddr);
            chk({nm, ".bus_wstrb"}, c_wstrb, v.e_wstrb);
            chk({nm, ".bus_wdata"}, c_wdata, v.e_bwdata);
            chk({nm, ".bus_we"}, c_we, v.we);
        end
        @(negedge clk);
        chk({nm, ".done_pulse"}, {lsu_done, lsu_fault}, 2'b00);
        chk({nm, ".rdata_pulse"}, rdata, 0);
    endtask

    initial begin
        logic [6:0] done_seen;
        logic [6:0] stall_seen;
        int         dcount;
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; ByteAccess = '0; ByteSrc = '0;
        addr = '0; wdata = '0;
        bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;

        //          we ba     bs      addr          wdata         brdata        rdy rv dr
        vecs[0]  = '{1, 2'b01, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 0, 0,
                     32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 0, 2, 1};
        vecs[1]  = '{0, 2'b01, 3'b010, 32'h0000_2001, 32'h0, 32'h0000_8000,         0, 2, 0,
                     32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 4, 1};
        vecs[2]  = '{0, 2'b10, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000,         1, 0, 0,
                     32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001, 0, 3, 2};
        vecs[3]  = '{1, 2'b10, 3'b011, 32'h0000_4002, 32'h1234_BEEF, 32'h0,         2, 0, 1,
                     32'h0000_4000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 4, 3};
        vecs[4]  = '{1, 2'b00, 3'b100, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0,         0, 0, 0,
                     32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 2, 1};
        vecs[5]  = '{0, 2'b00, 3'b100, 32'h0000_5004, 32'h0, 32'hCAFE_F00D,         0, 1, 0,
                     32'h0000_5004, 4'b0000, 32'h0, 32'hCAFE_F00D, 0, 3, 1};
        vecs[6]  = '{0, 2'b10, 3'b011, 32'h0000_6002, 32'h0, 32'h9ABC_0000,         0, 0, 0,
                     32'h0000_6000, 4'b0000, 32'h0, 32'hFFFF_9ABC, 0, 2, 1};
        vecs[7]  = '{0, 2'b01, 3'b000, 32'h0000_6003, 32'h0, 32'hF100_0000,         0, 0, 0,
                     32'h0000_6000, 4'b0000, 32'h0, 32'h0000_00F1, 0, 2, 1};
        vecs[8]  = '{1, 2'b11, 3'b100, 32'h0000_7000, 32'h0102_0304, 32'h0,         0, 0, 0,
                     32'h0000_7000, 4'b1111, 32'h0102_0304, 32'h0, 0, 2, 1};
        vecs[9]  = '{0, 2'b00, 3'b100, 32'h0000_8000, 32'h0, 32'h1234_5678,    100000, 0, 0,
                     32'h0000_8000, 4'b0000, 32'h0, 32'h0, 1, 256, 255};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{0, 2'b10, 3'b011, 32'h0000_3001, 32'h0, 32'h1234_8765,         0, 0, 0,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1, 1, 0};
        vecs[11] = '{0, 2'b00, 3'b100, 32'h0000_5006, 32'h0, 32'h1122_3344,         0, 0, 0,
                     32'h0, 4'b0000, 32'h0, 32'h0, 1, 1, 0};
`else
        vecs[10] = '{0, 2'b10, 3'b011, 32'h0000_3001, 32'h0, 32'h1234_8765,         0, 0, 0,
                     32'h0000_3000, 4'b0000, 32'h0, 32'hFFFF_8765, 0, 2, 1};
        vecs[11] = '{0, 2'b00, 3'b100, 32'h0000_5006, 32'h0, 32'h1122_3344,         0, 0, 0,
                     32'h0000_5004, 4'b0000, 32'h0, 32'h1122_3344, 0, 2, 1};
`endif
        vecs[12] = '{0, 2'b00, 3'b100, 32'h0000_D008, 32'h0, 32'h0BAD_F00D,         0, 0, 0,
                     32'h0000_D008, 4'b0000, 32'h0, 32'h0BAD_F00D, 0, 2, 1};

        repeat (2) @(negedge clk);
        chk("reset.valid", bif.bus_valid, 0);
        chk("reset.done_fault", {lsu_done, lsu_fault, lsu_stall}, 3'b000);
        chk("reset.rdata", rdata, 0);
        chk("reset.bus_addr", bif.bus_addr, 0);
        chk("reset.bus_strb_we", {bif.bus_wstrb, bif.bus_we}, 5'b0);
        chk("reset.bus_wdata", bif.bus_wdata, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back sw then lw on a zero-wait bus.
        @(negedge clk);
        bif.bus_ready = 1'b1; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h1357_9BDF;
        mem_req = 1'b1; mem_we = 1'b1; ByteAccess = 2'b00; ByteSrc = 3'b100;
        addr = 32'h0000_A000; wdata = 32'h2468_ACE0;
        done_seen = '0; stall_seen = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            done_seen[c]  = lsu_done;
            stall_seen[c] = lsu_stall;
            if (c == 2) begin
                mem_we = 1'b0; addr = 32'h0000_A004;
            end
            if (c == 5) begin
                chk("b2b.lw_rdata", rdata, 32'h1357_9BDF);
                mem_req = 1'b0;
            end
        end
        bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0;
        chk("b2b.done_cycles", done_seen, 7'b0100100);
        chk("b2b.stall_cycles", stall_seen, 7'b0011010);

        // Reset while REQ is holding bus_valid.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; ByteAccess = 2'b00; ByteSrc = 3'b100;
        addr = 32'h0000_B000;
        repeat (3) @(negedge clk);
        chk("rst_req.valid_before", bif.bus_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_req.valid_async", bif.bus_valid, 0);
        mem_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Reset while in WAIT_R; a late rvalid must not complete the discarded load.
        @(negedge clk);
        mem_req = 1'b1; addr = 32'h0000_C000;
        @(negedge clk);
        bif.bus_ready = 1'b1;
        @(negedge clk);
        bif.bus_ready = 1'b0;
        chk("rst_wait.valid_in_wait", {bif.bus_valid, lsu_done}, 2'b00);
        reset_n = 1'b0;
        #1;
        mem_req = 1'b0; bif.bus_rvalid = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        repeat (4) begin
            @(negedge clk);
            dcount += int'(lsu_done) + int'(bif.bus_valid);
        end
        bif.bus_rvalid = 1'b0;
        chk("rst_wait.idle_after", dcount, 0);
        run_vec("post_rst_lw", vecs[12]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
